tape_ram_scheduler: RTL and testbench
=====================================

Name: tape_ram_scheduler

Overview:
- Sequences ownership of one tape block RAM (string tape or struct tape) between two requesters: the parser-side tape writer and the host-side tape reader.
- Runs a per-document phase machine: idle, writer owns the RAM, drain, reader owns the RAM.
- Arbitrates single-cycle RAM accesses and tags read returns with a fixed-latency valid.
- One instance sits in front of each tape RAM, between the parser core and the RAM port.

Parameters:
NUMWORDS, 4096, tape depth in entries; overridden per tape with the Core tape-length constants
DW, 64, tape entry width in bits
AW, $clog2(NUMWORDS), address width
READ_LATENCY, 2, RAM read latency in cycles (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
doc_start  in  1  pulse: begin new document
doc_end  in  1  pulse: writer finished document
host_release  in  1  pulse: host done reading tape
w_req  in  1  writer access request (write only)
w_addr  in  AW  writer address
w_data  in  DW  writer data
w_gnt  out  1  writer access accepted this cycle
r_req  in  1  reader access request
r_addr  in  AW  reader address
r_gnt  out  1  reader access accepted this cycle
r_valid  out  1  read data valid
r_data  out  DW  read data
ram_en, ram_we  out  1,1  RAM enable / write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data
phase  out  2  0=IDLE 1=WRITE 2=DRAIN 3=READ
wr_count  out  AW+1  tape length: highest written address + 1
overflow  out  1  sticky: write with w_addr >= NUMWORDS
stall_count  out  32  stats (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert):
  - phase=IDLE; wr_count=0; overflow=0; r_valid=0; r_data=0.
  - Read pipeline cleared; stall_count=0.
- Grants are combinational from req and phase. RAM outputs are combinational from the granted requester. ram_en=0 when no grant.
- IDLE:
  - No grants.
  - doc_start -> WRITE next cycle; wr_count and overflow cleared on that edge.
- WRITE:
  - w_gnt=w_req. Writer has priority.
  - r_gnt=r_req & !w_req, which allows debug peeks while the writer is idle.
  - Granted write with w_addr<NUMWORDS: ram_en=1, ram_we=1; wr_count <= max(wr_count, w_addr+1).
  - Granted write with w_addr>=NUMWORDS: w_gnt=1, ram_en=0, overflow <= 1.
  - doc_end -> DRAIN. A write in the same cycle as doc_end is performed.
  - doc_start ignored.
- DRAIN:
  - No grants.
  - Stays until the read pipeline holds no outstanding reads (at most READ_LATENCY cycles), then -> READ.
  - If the pipeline is already empty, DRAIN lasts exactly 1 cycle.
- READ:
  - r_gnt=r_req; w_gnt=0.
  - host_release -> IDLE. A read in the same cycle is still granted and returned.
  - doc_start ignored unless it coincides with host_release; it is then still ignored, and the phase goes to IDLE.
- Read returns:
  - Each granted read asserts r_valid exactly READ_LATENCY cycles later, with r_data=ram_rdata in that cycle.
  - Back-to-back reads return back-to-back.
  - r_data holds its last value when r_valid=0.
  - Reads in flight complete across phase changes.
- doc_end outside WRITE and host_release outside READ are ignored.
- Reset mid-operation aborts the document. Outstanding reads are dropped: no r_valid after reset.

Optional Feature:
TAPE_SCHED_STATS_EN
- Defined: stall_count increments (saturating at 2^32-1) every cycle with r_req=1 & r_gnt=0. It clears on doc_start accepted in IDLE and on reset.
- Undefined: stall_count is tied to 0 and no counter logic is generated. The port list is unchanged.

Test Plan:
1. Reset; doc_start; writes addr 0..9 data=addr*3; doc_end -> wr_count=10, overflow=0, phase 1->2->3 with 1-cycle DRAIN.
2. READ phase, reads addr 0..9 back-to-back -> r_valid on 10 consecutive cycles starting READ_LATENCY after the first grant, r_data=0,3,...,27.
3. WRITE phase, w_req and r_req together on addr 5 -> w_gnt=1, r_gnt=0. Next cycle r_req alone -> r_gnt=1, and the value returned is the newly written data.
4. Write to addr NUMWORDS -> w_gnt=1, ram_en=0, overflow=1 and stays 1; wr_count unchanged.
5. Read granted in the last WRITE cycle, doc_end same cycle -> DRAIN lasts until r_valid is asserted, then READ. host_release -> IDLE, where w_req and r_req get no grant.
6. Assert rst_n=0 mid-READ with 2 reads in flight -> outputs reset immediately, no r_valid afterwards. With TAPE_SCHED_STATS_EN, 7 blocked r_req cycles -> stall_count=7.

Source files
------------

// File: rtl/tape_ram_scheduler.sv
// Tape RAM ownership scheduler: IDLE/WRITE/DRAIN/READ phases, single-port arbitration, read-return tagging.
// Optional stall statistics counter enabled by defining TAPE_SCHED_STATS_EN.
module tape_ram_scheduler #(
  parameter int NUMWORDS     = 4096,
  parameter int DW           = 64,
  parameter int AW           = $clog2(NUMWORDS),
  parameter int READ_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          doc_start,
  input  logic          doc_end,
  input  logic          host_release,
  input  logic          w_req,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic          w_gnt,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic          r_gnt,
  output logic          r_valid,
  output logic [DW-1:0] r_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    phase,
  output logic [AW:0]   wr_count,
  output logic          overflow,
  output logic [31:0]   stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2,
    READ  = 2'd3
  } state_t;

  localparam logic [AW:0] NUMWORDS_W = (AW+1)'(NUMWORDS);

  state_t                  state;
  logic [READ_LATENCY-1:0] pipe;
  logic [DW-1:0]           r_hold;
  logic                    w_ovf;
  logic [AW:0]             w_addr_p1;
  logic                    pending;

  assign phase     = state;
  assign w_ovf     = ({1'b0, w_addr} >= NUMWORDS_W);
  assign w_addr_p1 = {1'b0, w_addr} + (AW+1)'(1);

  assign w_gnt = (state == WRITE) && w_req;
  assign r_gnt = ((state == WRITE) && r_req && !w_req) || ((state == READ) && r_req);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_gnt) begin
      ram_en    = !w_ovf;
      ram_we    = !w_ovf;
      ram_addr  = w_addr;
      ram_wdata = w_data;
    end else if (r_gnt) begin
      ram_en   = 1'b1;
      ram_addr = r_addr;
    end
  end

  // Reads still travelling toward the output; the one returning this cycle does not hold DRAIN.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < READ_LATENCY; i++) pending = pending | pipe[i];
  end

  assign r_valid = pipe[READ_LATENCY-1];
  assign r_data  = r_valid ? ram_rdata : r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe   <= '0;
      r_hold <= '0;
    end else begin
      pipe[0] <= r_gnt;
      for (int unsigned i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      r_hold <= r_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (doc_start) begin
            state    <= WRITE;
            wr_count <= '0;
            overflow <= 1'b0;
          end
        end
        WRITE: begin
          if (w_gnt) begin
            if (w_ovf) overflow <= 1'b1;
            else if (w_addr_p1 > wr_count) wr_count <= w_addr_p1;
          end
          if (doc_end) state <= DRAIN;
        end
        DRAIN: begin
          if (!pending) state <= READ;
        end
        READ: begin
          if (host_release) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TAPE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if ((state == IDLE) && doc_start) begin
      stall_count <= '0;
    end else if (r_req && !r_gnt && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_tape_ram_scheduler.sv
// Self-checking bench for tape_ram_scheduler: behavioural RAM, scoreboard of expected read returns.
// Build with TAPE_SCHED_STATS_EN defined to also check the stall counter.
module tb_tape_ram_scheduler;

  localparam int NW = 100;
  localparam int DW = 64;
  localparam int AW = $clog2(NW);
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          doc_start, doc_end, host_release;
  logic          w_req, r_req;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;
  logic          w_gnt, r_gnt, r_valid;
  logic [DW-1:0] r_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [1:0]    phase;
  logic [AW:0]   wr_count;
  logic          overflow;
  logic [31:0]   stall_count;

  tape_ram_scheduler #(.NUMWORDS(NW), .DW(DW), .AW(AW), .READ_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .doc_start(doc_start), .doc_end(doc_end),
    .host_release(host_release), .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
    .w_gnt(w_gnt), .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_valid(r_valid),
    .r_data(r_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .phase(phase), .wr_count(wr_count),
    .overflow(overflow), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with L-cycle read latency; idle cycles return a filler pattern.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rp  [0:L-1];
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    rp[0] <= ram_en ? mem[ram_addr] : 64'h5a5a_5a5a_5a5a_5a5a;
    for (int k = 1; k < L; k++) rp[k] <= rp[k-1];
  end
  assign ram_rdata = rp[L-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] shadow [0:NW-1];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    doc_start = 0; doc_end = 0; host_release = 0;
    w_req = 0; r_req = 0;
  endtask

  task automatic expect_read(input logic [AW-1:0] a);
    q.push_back('{cyc + L, shadow[a]});
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rd_valid", r_valid, 1);
      chk("rd_data", r_data, q[0].data);
      void'(q.pop_front());
    end else if (r_valid) begin
      chk("rd_unexpected", r_valid, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; clear_inputs(); w_addr = '0; r_addr = '0; w_data = '0;
    #3;
    chk("rst_phase", phase, 0);
    chk("rst_wrcount", wr_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_stall", stall_count, 0);
    @(posedge clk); #1 rst_n = 1;
    tick();

    // Test 1: fill 0..9 with addr*3, doc_end on the final write
    doc_start = 1;
    tick();
    doc_start = 0;
    chk("t1_phase_write", phase, 1);
    for (int i = 0; i < 10; i++) begin
      w_req = 1; w_addr = AW'(i); w_data = DW'(i * 3);
      shadow[i] = DW'(i * 3);
      doc_end = (i == 9);
      @(negedge clk);
      chk("t1_wgnt", w_gnt, 1);
      chk("t1_ram_en_we", {ram_en, ram_we}, 2'b11);
      chk("t1_ram_addr", ram_addr, i);
      tick();
    end
    clear_inputs();
    chk("t1_phase_drain", phase, 2);
    chk("t1_wrcount", wr_count, 10);
    chk("t1_overflow", overflow, 0);
    tick();
    chk("t1_phase_read", phase, 3);

    // Test 2: back-to-back read-back
    for (int i = 0; i < 10; i++) begin
      r_req = 1; r_addr = AW'(i);
      expect_read(AW'(i));
      @(negedge clk);
      chk("t2_rgnt", r_gnt, 1);
      tick();
    end
    r_req = 0;
    repeat (L + 2) tick();
    chk("t2_drained", q.size(), 0);
    chk("t2_rdata_hold", r_data, 27);
    host_release = 1;
    tick();
    clear_inputs();
    chk("t2_phase_idle", phase, 0);

    // Test 3: writer priority, then peek sees fresh data
    doc_start = 1;
    tick();
    clear_inputs();
    chk("t3_phase_write", phase, 1);
    chk("t3_wrcount_cleared", wr_count, 0);
    w_req = 1; w_addr = 5; w_data = 64'hdead_beef_0000_0005;
    r_req = 1; r_addr = 5;
    shadow[5] = 64'hdead_beef_0000_0005;
    @(negedge clk);
    chk("t3_wgnt", w_gnt, 1);
    chk("t3_rgnt_blocked", r_gnt, 0);
    tick();
    w_req = 0;
    expect_read(5);
    @(negedge clk);
    chk("t3_rgnt_peek", r_gnt, 1);
    tick();
    r_req = 0;
    chk("t3_wrcount", wr_count, 6);
    repeat (L) tick();

    // Test 4: out-of-range write
    w_req = 1; w_addr = AW'(NW); w_data = 64'h1234;
    @(negedge clk);
    chk("t4_wgnt", w_gnt, 1);
    chk("t4_ram_en", ram_en, 0);
    tick();
    w_addr = 2; w_data = 64'h0202;
    shadow[2] = 64'h0202;
    tick();
    w_req = 0;
    chk("t4_overflow", overflow, 1);
    chk("t4_wrcount", wr_count, 6);
    repeat (2) tick();
    chk("t4_overflow_sticky", overflow, 1);

    // Test 5: read in the last WRITE cycle stretches DRAIN
    r_req = 1; r_addr = 2; doc_end = 1;
    expect_read(2);
    @(negedge clk);
    chk("t5_rgnt", r_gnt, 1);
    tick();
    clear_inputs();
    chk("t5_drain_a", phase, 2);
    tick();
    chk("t5_drain_b", phase, 2);
    chk("t5_rvalid_in_drain", r_valid, 1);
    tick();
    chk("t5_phase_read", phase, 3);
    r_req = 1; r_addr = 5; host_release = 1; doc_start = 1;
    expect_read(5);
    @(negedge clk);
    chk("t5_rgnt_release", r_gnt, 1);
    tick();
    clear_inputs();
    chk("t5_phase_idle", phase, 0);
    w_req = 1; r_req = 1; w_addr = 1; r_addr = 1; doc_end = 1;
    @(negedge clk);
    chk("t5_idle_gnts", {w_gnt, r_gnt, ram_en}, 3'b000);
    tick();
    clear_inputs();
    chk("t5_idle_stays", phase, 0);
    repeat (L) tick();

    // Test 6: reset with two reads in flight
    doc_start = 1; tick();
    clear_inputs(); doc_end = 1; tick();
    clear_inputs(); tick();
    chk("t6_phase_read", phase, 3);
    for (int i = 0; i < 2; i++) begin
      r_req = 1; r_addr = AW'(i);
      expect_read(AW'(i));
      tick();
    end
    clear_inputs();
    rst_n = 0;
    q.delete();
    #1;
    chk("t6_rst_rvalid", r_valid, 0);
    chk("t6_rst_phase", phase, 0);
    chk("t6_rst_wrcount", wr_count, 0);
    chk("t6_rst_rdata", r_data, 0);
    tick();
    rst_n = 1;
    repeat (L + 2) tick();

    // Stall statistics: blocked reader in IDLE
    for (int i = 0; i < 7; i++) begin
      r_req = 1; r_addr = 0;
      @(negedge clk);
      chk("t6_idle_rgnt", r_gnt, 0);
      tick();
    end
    r_req = 0;
`ifdef TAPE_SCHED_STATS_EN
    chk("t6_stall_count", stall_count, 7);
    doc_start = 1;
    tick();
    clear_inputs();
    chk("t6_stall_cleared", stall_count, 0);
`else
    chk("t6_stall_tied", stall_count, 0);
`endif

    repeat (L + 2) tick();
    chk("final_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
